median_filter_frame_ctrl: RTL and testbench

Frame sequencer for the 3×3 median filter stage. It accepts a start command and pulls pixels from a valid/ready source such as a frame-buffer reader. It generates the per_img_vsync/href/gray stream, with programmable vertical and horizontal blanking, that the line-buffered filter requires. It then watches the filter's output stream to detect frame completion and check the output pixel count.

---
 rtl/median_filter_frame_ctrl_if.sv | 19 +
 rtl/median_filter_frame_ctrl.sv | 83 ++++++++
 tb/tb_median_filter_frame_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/median_filter_frame_ctrl_if.sv
// median_filter_frame_ctrl_if: source pixel stream, stream to the filter and filter output sync.
interface median_filter_frame_ctrl_if;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] src_data;
  logic       per_img_vsync;
  logic       per_img_href;
  logic [7:0] per_img_gray;
  logic       flt_vsync;
  logic       flt_href;
  modport master (
    output src_valid, src_data, flt_vsync, flt_href,
    input  src_ready, per_img_vsync, per_img_href, per_img_gray
  );
  modport slave (
    input  src_valid, src_data, flt_vsync, flt_href,
    output src_ready, per_img_vsync, per_img_href, per_img_gray
  );
endinterface

// File: rtl/median_filter_frame_ctrl.sv
// median_filter_frame_ctrl: sequences one blanked frame into the median filter and checks its output.
module median_filter_frame_ctrl #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [10:0] H_BLANK   = 11'd160,
  parameter logic [10:0] V_PRE     = 11'd16,
  parameter logic [10:0] V_POST    = 11'd800
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  median_filter_frame_ctrl_if.slave  bus,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       frame_ok,
  output logic                       src_underflow,
  output logic [15:0]                frame_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_VPRE, S_LINE, S_HBLK, S_VPOST, S_DRAIN} state_t;
  localparam logic [21:0] PIX_TOTAL = 22'(IMG_HDISP) * 22'(IMG_VDISP);
  state_t      state, nxt;
  logic [10:0] phase, col, row;
  logic [21:0] pix_cnt;
  logic        flt_seen, start_acc;
  assign busy          = state != S_IDLE;
  assign bus.src_ready = state == S_LINE;
  assign start_acc     = state == S_IDLE && start && !abort;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  always_comb begin
    nxt        = state;
    frame_done = 1'b0;
    case (state)
      S_IDLE:  if (start) nxt = S_VPRE;
      S_VPRE:  if (phase == V_PRE - 11'd1) nxt = S_LINE;
      S_LINE:  if (col == IMG_HDISP - 11'd1) nxt = (row == IMG_VDISP - 11'd1) ? S_VPOST : S_HBLK;
      S_HBLK:  if (phase == H_BLANK - 11'd1) nxt = S_LINE;
      S_VPOST: if (phase == V_POST - 11'd1) nxt = S_DRAIN;
      S_DRAIN: if (flt_seen && !bus.flt_vsync) begin
        nxt        = S_IDLE;
        frame_done = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
    if (abort) begin
      nxt        = S_IDLE;
      frame_done = 1'b0;
    end
  end
  // Phase and column restart on every state change; row survives blanking until the next frame.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase             <= '0;
      col               <= '0;
      row               <= '0;
      bus.per_img_href  <= 1'b0;
      bus.per_img_vsync <= 1'b0;
      bus.per_img_gray  <= '0;
      src_underflow     <= 1'b0;
      pix_cnt           <= '0;
      flt_seen          <= 1'b0;
      frame_ok          <= 1'b0;
      frame_cnt         <= '0;
    end else begin
      phase             <= (nxt == state && state inside {S_VPRE, S_HBLK, S_VPOST}) ? phase + 11'd1 : 11'd0;
      col               <= (nxt == state && state == S_LINE) ? col + 11'd1 : 11'd0;
      row               <= (nxt == S_IDLE || nxt == S_VPRE) ? 11'd0 :
                           (state == S_LINE && nxt != S_LINE) ? row + 11'd1 : row;
      bus.per_img_href  <= state == S_LINE;
      bus.per_img_vsync <= state inside {S_VPRE, S_LINE, S_HBLK, S_VPOST};
      bus.per_img_gray  <= (state == S_LINE && bus.src_valid) ? bus.src_data : 8'd0;
      src_underflow     <= start_acc ? 1'b0 : src_underflow | (bus.src_ready & ~bus.src_valid);
      pix_cnt           <= start_acc ? 22'd0 : pix_cnt + 22'(bus.flt_href && busy);
      flt_seen          <= start_acc ? 1'b0 :
                           flt_seen | (bus.flt_vsync && state inside {S_LINE, S_HBLK, S_VPOST, S_DRAIN});
      if (frame_done) begin
        frame_ok  <= pix_cnt == PIX_TOTAL;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
endmodule

// File: tb/tb_median_filter_frame_ctrl.sv
// tb_median_filter_frame_ctrl: directed frames with a pixel scoreboard and a delayed filter loopback.
module tb_median_filter_frame_ctrl;
  localparam int HD = 4, VD = 3, HB = 2, VPR = 3, VPO = 5;
  localparam int VS_LEN = VPR + HD * VD + (VD - 1) * HB + VPO;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic busy, frame_done, frame_ok, src_underflow;
  logic [15:0] frame_cnt;
  int tests = 0, fails = 0;
  median_filter_frame_ctrl_if bus();
  median_filter_frame_ctrl #(
    .IMG_HDISP(11'd4), .IMG_VDISP(11'd3), .H_BLANK(11'd2), .V_PRE(11'd3), .V_POST(11'd5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus.slave),
    .busy(busy), .frame_done(frame_done), .frame_ok(frame_ok),
    .src_underflow(src_underflow), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  // Filter loopback: the per_img sync delayed two cycles, href optionally cut after flt_limit pixels.
  logic [1:0] vs_d, hr_d;
  int fh_cnt, flt_limit = 1000;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_d <= '0; hr_d <= '0; fh_cnt <= 0;
    end else begin
      vs_d   <= {vs_d[0], bus.per_img_vsync};
      hr_d   <= {hr_d[0], bus.per_img_href};
      fh_cnt <= (bus.per_img_vsync && !vs_d[0]) ? 0 : fh_cnt + (bus.flt_href ? 1 : 0);
    end
  assign bus.flt_vsync = vs_d[1];
  assign bus.flt_href  = hr_d[1] && fh_cnt < flt_limit;
  logic [7:0] sb[$];
  logic [7:0] exp_g;
  int ramp = 0, drop_at = -1, vs_len = 0, last_vs_len = 0, hrun = 0, gap = 0, lines = 0;
  int runs = 0, bad = 0, dones = 0;
  logic prev_vs = 1'b0, prev_href = 1'b0;
  // Monitor (outputs of the last edge) then drive the source for the next edge.
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else if (bus.per_img_href) begin
      tests++;
      exp_g = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      assert (bus.per_img_gray === exp_g) else begin
        fails++;
        $error("FAIL gray observed=%0d expected=%0d", bus.per_img_gray, exp_g);
      end
    end
    if (bus.per_img_vsync && !prev_vs) begin gap = 0; lines = 0; vs_len = 0; end
    if (bus.per_img_vsync) vs_len++;
    else if (prev_vs) last_vs_len = vs_len;
    if (bus.per_img_href) begin
      if (!prev_href) begin
        if (gap != (lines == 0 ? VPR : HB)) bad++;
        lines++;
      end
      hrun++;
      gap = 0;
    end else begin
      if (prev_href) begin
        runs++;
        if (hrun != HD) bad++;
      end
      hrun = 0;
      if (bus.per_img_vsync) gap++;
    end
    if (frame_done) dones++;
    prev_vs   = bus.per_img_vsync;
    prev_href = bus.per_img_href;
    if (!busy) ramp = 0;
    bus.src_valid = ramp != drop_at;
    bus.src_data  = ramp[7:0];
    if (bus.src_ready) begin
      sb.push_back(bus.src_valid ? bus.src_data : 8'd0);
      ramp++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic start_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask
  task automatic run_to_done(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = frame_done;
    end
    chk({tag, "_done_seen"}, 32'(got), 1);
    @(negedge clk);
  endtask
  task automatic nominal(input string tag, input int exp_cnt);
    int d0 = dones, b0 = bad, r0 = runs;
    start_frame();
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_vsync_lag"}, 32'(bus.per_img_vsync), 0);
    @(negedge clk); chk({tag, "_vsync_rise"}, 32'(bus.per_img_vsync), 1);
    @(negedge clk); chk({tag, "_ready_pre"}, 32'(bus.src_ready), 0);
    @(negedge clk); chk({tag, "_ready_rise"}, {bus.src_ready, bus.per_img_href}, 2'b10);
    @(negedge clk); chk({tag, "_href_rise"}, 32'(bus.per_img_href), 1);
    run_to_done(tag);
    chk({tag, "_vs_len"}, last_vs_len, VS_LEN);
    chk({tag, "_lines"}, runs - r0, VD);
    chk({tag, "_shape"}, bad - b0, 0);
    chk({tag, "_one_done"}, dones - d0, 1);
    chk({tag, "_ok"}, 32'(frame_ok), 1);
    chk({tag, "_cnt"}, 32'(frame_cnt), exp_cnt);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask
  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, bus.src_ready, bus.per_img_vsync, bus.per_img_href, bus.per_img_gray,
                       frame_done, frame_ok, src_underflow, frame_cnt}, 0);
    rst_n = 1'b1;
    nominal("nom", 1);
    chk("nom_underflow", 32'(src_underflow), 0);
    drop_at = 6;
    nominal("drop", 2);
    chk("drop_underflow", 32'(src_underflow), 1);
    drop_at = -1;
    d0 = dones;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    chk("held_busy", 32'(busy), 1);
    chk("held_underflow_clr", 32'(src_underflow), 0);
    run_to_done("held");
    start = 1'b0;
    chk("held_ignored", 32'(busy), 0);
    chk("held_one_done", dones - d0, 1);
    chk("held_cnt", 32'(frame_cnt), 3);
    nominal("frame2", 4);
    d0 = dones;
    start_frame();
    repeat (10) @(negedge clk);
    chk("abort_in_line", 32'(bus.src_ready), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy_ready", {busy, bus.src_ready}, 0);
    chk("abort_vsync_lag", 32'(bus.per_img_vsync), 1);
    @(negedge clk);
    chk("abort_sync_low", {bus.per_img_vsync, bus.per_img_href}, 0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", dones - d0, 0);
    chk("abort_cnt", 32'(frame_cnt), 4);
    chk("abort_sb_empty", sb.size(), 0);
    flt_limit = 11;
    start_frame();
    run_to_done("short");
    chk("short_ok", 32'(frame_ok), 0);
    chk("short_cnt", 32'(frame_cnt), 5);
    flt_limit = 1000;
    start_frame();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_outs", {busy, bus.src_ready, bus.per_img_vsync, bus.per_img_href, bus.per_img_gray,
                        frame_done, frame_ok, src_underflow, frame_cnt}, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    nominal("post_rst", 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
